// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer: feeds one operand bit pair per cycle,
// LSB first, to an external full-adder cell and collects the sum.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    fa_a     = 1'b0;
    fa_b     = 1'b0;
    fa_cin   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = op_a;
          b_sr_d  = op_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        fa_a     = a_sr_q[0];
        fa_b     = b_sr_q[0];
        fa_cin   = carry_q;
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        // Last bit: publish the completed word in the same edge.
        if (cnt_q == LAST) begin
          sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed and random checks of serial_adder_seq with a behavioural
// full-adder cell and an arithmetic reference model.
module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         fa_a, fa_b, fa_cin, fa_s, fa_co;

  int n_checks = 0;
  int n_err = 0;
  int done_cnt = 0;
  int accepts = 0;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_s(fa_s), .fa_co(fa_co)
  );

  // the full-adder cell environment
  assign fa_s  = fa_a ^ fa_b ^ fa_cin;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op in IDLE, run until done (bounded), then step into IDLE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input bit inject,
                       output int lat, output int bcnt,
                       output logic [W-1:0] fseq, output logic fcin0);
    start = 1'b1; op_a = a; op_b = b; cin = c;
    tick();
    accepts++;
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
    lat = 0; bcnt = 0; fseq = '0; fcin0 = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat < W) fseq[lat] = fa_a;
      if (lat == 0) fcin0 = fa_cin;
      if (busy === 1'b1) bcnt++;
      if (inject && lat == 3) begin
        start = 1'b1; op_a = 8'hFF;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    if (busy === 1'b1) bcnt++;
    if (inject) begin
      start = 1'b1; op_a = 8'hFF;
    end
    tick();
    start = 1'b0;
  endtask

  initial begin
    int lat, bcnt, d0, a0;
    logic [W-1:0] fseq;
    logic fcin0;
    logic [W-1:0] ra, rb;
    logic rc;
    logic [W:0] ref_v;

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_fa", {fa_a, fa_b, fa_cin}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 0xFF + 0x01
    d0 = done_cnt;
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, bcnt, fseq, fcin0);
    check("t1_lat", lat, W);
    check("t1_busy_cycles", bcnt, W + 1);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_sum", sum, 8'h00);
    check("t1_cout", cout, 1);
    check("t1_idle", busy, 0);

    // 0x5A + 0xA5 + 1
    do_op(8'h5A, 8'hA5, 1'b1, 1'b0, lat, bcnt, fseq, fcin0);
    check("t2_sum", sum, 8'h00);
    check("t2_cout", cout, 1);
    check("t2_fa_a_seq", fseq, 8'h5A);
    check("t2_fa_cin0", fcin0, 1);

    // 0 + 0 + 1, then hold
    do_op(8'h00, 8'h00, 1'b1, 1'b0, lat, bcnt, fseq, fcin0);
    check("t3_sum", sum, 8'h01);
    check("t3_cout", cout, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_hold", {busy, cout, sum}, {1'b0, 1'b0, 8'h01});
    end

    // starts in RUN and DONE are ignored
    d0 = done_cnt;
    do_op(8'h12, 8'h34, 1'b0, 1'b1, lat, bcnt, fseq, fcin0);
    check("t4_lat", lat, W);
    check("t4_sum", sum, 8'h46);
    check("t4_cout", cout, 0);
    check("t4_done_once", done_cnt - d0, 1);
    check("t4_idle", busy, 0);
    do_op(8'h10, 8'h20, 1'b0, 1'b0, lat, bcnt, fseq, fcin0);
    check("t4_third_lat", lat, W);
    check("t4_third_sum", {cout, sum}, 9'h030);

    // reset mid-RUN
    d0 = done_cnt;
    start = 1'b1; op_a = 8'h80; op_b = 8'h80; cin = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t5_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_sum", sum, 0);
    check("t5_cout", cout, 0);
    check("t5_fa", {fa_a, fa_b, fa_cin}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("t5_no_done", done_cnt - d0, 0);
    do_op(8'h80, 8'h80, 1'b0, 1'b0, lat, bcnt, fseq, fcin0);
    check("t5_after_sum", sum, 8'h00);
    check("t5_after_cout", cout, 1);

    // random back-to-back
    d0 = done_cnt;
    a0 = accepts;
    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op(ra, rb, rc, 1'b0, lat, bcnt, fseq, fcin0);
      check("rnd_result", {cout, sum}, ref_v);
      check("rnd_lat", lat, W);
    end
    check("rnd_done_count", done_cnt - d0, accepts - a0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
